// File: rtl/dmem_store_buf.sv
// Data-memory responder: stores post into a FIFO buffer that drains to the word array on idle cycles;
// loads return combinationally with buffered bytes merged in. Optional err_o port via DMEM_MISALIGN_EN.
module dmem_store_buf #(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce_i,
    input  logic                      we_i,
    input  logic [31:0]               addr_i,
    input  logic [3:0]                sel_i,
    input  logic [31:0]               data_i,
    output logic [31:0]               data_o,
    output logic                      stall_o,
    output logic [$clog2(DEPTH):0]    count_o
`ifdef DMEM_MISALIGN_EN
    ,
    output logic                      err_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_idx [DEPTH];
    logic [3:0]    r_sel [DEPTH];
    logic [31:0]   r_dat [DEPTH];
    logic [31:0]   r_mem [2**AW];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    logic [AW-1:0] w_idx;
    logic          w_err;
    logic          w_store;
    logic          w_load;
    logic          w_full;
    logic          w_enq;
    logic          w_drain;
    logic [31:0]   w_fwd;
    logic [PW-1:0] w_pos;
    logic          w_unused;

    assign w_idx    = addr_i[AW+1:2];
    assign w_unused = &{1'b0, addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_MISALIGN_EN
    assign w_err = rst & ce_i &
                   (((sel_i == 4'hF) && (addr_i[1:0] != 2'b00)) ||
                    (((sel_i == 4'h3) || (sel_i == 4'hC)) && addr_i[0]));
    assign err_o = w_err;
`else
    assign w_err = 1'b0;
`endif

    assign w_store = rst & ce_i & we_i & ~w_err;
    assign w_load  = rst & ce_i & ~we_i & ~w_err;
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign stall_o = w_store & (|sel_i) & w_full;
    assign w_enq   = w_store & (|sel_i) & ~w_full;
    // A held store against a full buffer forces the oldest entry out so it can land next cycle.
    assign w_drain = rst & (((~ce_i) & (r_cnt != '0)) | stall_o);
    assign count_o = r_cnt;

    // Walk entries oldest to newest so the newest matching byte wins.
    always_comb begin
        w_fwd = r_mem[w_idx];
        w_pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_pos = r_rd + PW'(k);
            if ((CW'(k) < r_cnt) && (r_idx[w_pos] == w_idx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_sel[w_pos][b]) begin
                        w_fwd[8*b +: 8] = r_dat[w_pos][8*b +: 8];
                    end
                end
            end
        end
        data_o = '0;
        if (w_load) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    data_o[8*b +: 8] = w_fwd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_enq) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_drain) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry payloads and the array are not reset; validity lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_idx[r_wr] <= w_idx;
            r_sel[r_wr] <= sel_i;
            r_dat[r_wr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_drain) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sel[r_rd][b]) begin
                    r_mem[r_idx[r_rd]][8*b +: 8] <= r_dat[r_rd][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buf.sv
// Scoreboard bench for dmem_store_buf: a queue/array reference model predicts each cycle's outputs,
// a negedge monitor pops and compares. Define DMEM_MISALIGN_EN to cover err_o as well.
module tb_dmem_store_buf;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic [2:0]  count_o;
`ifdef DMEM_MISALIGN_EN
    logic        err_o;
`endif

    dmem_store_buf #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce_i    (ce_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .sel_i   (sel_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .stall_o (stall_o),
        .count_o (count_o)
`ifdef DMEM_MISALIGN_EN
        ,
        .err_o   (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] d;
        logic        st;
        logic [2:0]  cnt;
        logic        err;
    } exp_t;

    typedef struct {
        int          idx;
        logic [3:0]  sel;
        logic [31:0] dat;
    } ent_t;

    exp_t        sb[$];
    ent_t        mq[$];
    logic [31:0] mmem [1024];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        last_stall = 1'b0;

    // Reference model: buffer is a plain queue, array a plain word array.
    task automatic model(input logic c, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, output exp_t e);
        int          idx;
        logic        err;
        logic        st;
        logic [31:0] word;
        ent_t        ent;
        idx  = int'(a[AW+1:2]);
        err  = 1'b0;
`ifdef DMEM_MISALIGN_EN
        err = c && ((s == 4'hF && a[1:0] != 2'b00) || ((s == 4'h3 || s == 4'hC) && a[0]));
`endif
        st     = c && w && !err && s != 4'h0 && mq.size() == DEPTH;
        e.st   = st;
        e.err  = err;
        e.cnt  = 3'(mq.size());
        e.d    = 32'h0;
        if (c && !w && !err) begin
            word = mmem[idx];
            foreach (mq[i]) begin
                if (mq[i].idx == idx) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mq[i].sel[b]) word[8*b +: 8] = mq[i].dat[8*b +: 8];
                    end
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (s[b]) e.d[8*b +: 8] = word[8*b +: 8];
            end
        end
        if (st || (!c && mq.size() > 0)) begin
            ent = mq.pop_front();
            for (int b = 0; b < 4; b++) begin
                if (ent.sel[b]) mmem[ent.idx][8*b +: 8] = ent.dat[8*b +: 8];
            end
        end
        if (c && w && !err && s != 4'h0 && !st) begin
            ent.idx = idx;
            ent.sel = s;
            ent.dat = d;
            mq.push_back(ent);
        end
    endtask

    task automatic cyc(input logic c, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1; ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
        model(c, w, a, s, d, e);
        e.nm = nm;
        sb.push_back(e);
        last_stall = e.st;
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
        mq.delete();
        e.nm = nm; e.d = '0; e.st = 1'b0; e.cnt = 3'd0; e.err = 1'b0;
        sb.push_back(e);
        last_stall = 1'b0;
    endtask

    task automatic st_w(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input string nm);
        cyc(1'b1, 1'b1, a, s, d, nm);
        if (last_stall) cyc(1'b1, 1'b1, a, s, d, {nm, "_held"});
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] s, input string nm);
        cyc(1'b1, 1'b0, a, s, 32'h0, nm);
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, nm);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "data_o", data_o, e.d);
                chk(e.nm, "stall_o", {31'h0, stall_o}, {31'h0, e.st});
                chk(e.nm, "count_o", {29'h0, count_o}, {29'h0, e.cnt});
`ifdef DMEM_MISALIGN_EN
                chk(e.nm, "err_o", {31'h0, err_o}, {31'h0, e.err});
`endif
            end
        end
    end

    logic [3:0] sel_tab [10];
    logic [31:0] sv_a;
    logic [31:0] sv_d;
    logic [3:0]  sv_s;

    initial begin : stim
        rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
        sel_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'hF, 4'h0, 4'h6};
        do_reset("reset");
        for (int w = 0; w < 16; w++) st_w(32'(w * 4), 4'hF, 32'h0, "init");
        idle(DEPTH + 1, "init_drain");

        st_w(32'h10, 4'hF, 32'h11223344, "fwd_st");
        ld(32'h10, 4'hF, "fwd_ld");
        idle(DEPTH + 1, "drain_a");

        st_w(32'h20, 4'hF, 32'hAABBCCDD, "merge_st0");
        st_w(32'h20, 4'h1, 32'h000000EE, "merge_st1");
        ld(32'h20, 4'hF, "merge_ld_fwd");
        idle(2, "merge_idle");
        ld(32'h20, 4'hF, "merge_ld_arr");
        ld(32'h20, 4'h6, "lane_mask");

        cyc(1'b1, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, "b2b0");
        cyc(1'b1, 1'b1, 32'h4, 4'hF, 32'hA1A1A1A1, "b2b1");
        cyc(1'b1, 1'b1, 32'h8, 4'hF, 32'hA2A2A2A2, "b2b2");
        cyc(1'b1, 1'b1, 32'hC, 4'hF, 32'hA3A3A3A3, "b2b3");
        cyc(1'b1, 1'b1, 32'h10, 4'hF, 32'hA4A4A4A4, "b2b_stall");
        cyc(1'b1, 1'b1, 32'h10, 4'hF, 32'hA4A4A4A4, "b2b_accept");
        cyc(1'b1, 1'b1, 32'h14, 4'h0, 32'hDEADBEEF, "sel0_noop");
        idle(DEPTH + 1, "drain_b");
        ld(32'h0, 4'hF, "b2b_arr0");

        st_w(32'h24, 4'hF, 32'h01010101, "rst_st0");
        st_w(32'h28, 4'hF, 32'h02020202, "rst_st1");
        st_w(32'h0, 4'hF, 32'h03030303, "rst_st2");
        do_reset("rst_mid");
        ld(32'h0, 4'hF, "rst_old0");
        ld(32'h24, 4'hF, "rst_old24");

        for (int i = 0; i < DEPTH; i++) st_w(32'(32 + 4 * i), 4'hF, 32'(32'h55000000 + i), "wrap_fill");
        idle(2, "wrap_idle");
        st_w(32'h3C, 4'h1, 32'h000000C1, "wrap_l0");
        st_w(32'h3C, 4'h2, 32'h0000C200, "wrap_l1");
        st_w(32'h3C, 4'h4, 32'h00C30000, "wrap_l2");
        ld(32'h3C, 4'hF, "wrap_ld");
        ld(32'h20, 4'hF, "wrap_ld_old");
        idle(DEPTH + 1, "drain_c");

`ifdef DMEM_MISALIGN_EN
        st_w(32'h8, 4'hF, 32'h77777777, "mis_pre");
        cyc(1'b1, 1'b1, 32'h2, 4'hF, 32'h12345678, "mis_st");
        cyc(1'b1, 1'b0, 32'h1, 4'h3, 32'h0, "mis_ld");
        idle(DEPTH + 1, "drain_d");
`endif

        for (int i = 0; i < 600; i++) begin
            if (last_stall) begin
                cyc(1'b1, 1'b1, sv_a, sv_s, sv_d, "rnd_hold");
            end else begin
                int p;
                p    = int'($urandom_range(0, 9));
                sv_a = 32'($urandom_range(0, 63));
                sv_s = sel_tab[$urandom_range(0, 9)];
                sv_d = $urandom;
                if (p < 3)      cyc(1'b0, 1'b0, sv_a, sv_s, sv_d, "rnd_idle");
                else if (p < 7) cyc(1'b1, 1'b1, sv_a, sv_s, sv_d, "rnd_st");
                else            cyc(1'b1, 1'b0, sv_a, sv_s, sv_d, "rnd_ld");
            end
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
